// File: rtl/sm4_pkg.sv
// sm4_pkg: SM4 S-box table, T-transform modes and the L / L' linear transforms
package sm4_pkg;
  typedef enum logic [1:0] {T = 2'b00, TP = 2'b01, TAU = 2'b10, TAU_ALT = 2'b11} sm4_tmode_e;
  localparam logic [0:255][7:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] sm4_l(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction
  function automatic logic [31:0] sm4_lp(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction
  // Both tau-only encodings pass the substituted word straight through.
  function automatic logic [31:0] sm4_lin(input sm4_tmode_e m, input logic [31:0] b);
    return m == T ? sm4_l(b) : m == TP ? sm4_lp(b) : b;
  endfunction
endpackage

// File: rtl/sm4_sbox_lut.sv
// sm4_sbox_lut: combinational 8-bit SM4 S-box lookup
module sm4_sbox_lut
  import sm4_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  assign s_o = SM4_SBOX[a_i];
endmodule

// File: rtl/sm4_tbox_pipe.sv
// sm4_tbox_pipe: pipelined multi-lane SM4 T / T' / tau transform with valid/ready flow control
module sm4_tbox_pipe
  import sm4_pkg::*;
#(
  parameter int LANES = 1,
  parameter int STAGES = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           in_mode_i,
  input  logic [TAG_W-1:0]     in_tag_i,
  input  logic [32*LANES-1:0]  in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [TAG_W-1:0]     out_tag_o,
  output logic [32*LANES-1:0]  out_data_o
);
  localparam int W = 32 * LANES;
  logic [W-1:0] tau_w, lin_w, fd;
  sm4_tmode_e fm;
  logic [TAG_W-1:0] ft;
  logic fv, ld2;
  logic v2_q, v2_d;
  logic [W-1:0] d2_q, d2_d;
  logic [TAG_W-1:0] t2_q, t2_d;
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("sm4_tbox_pipe: STAGES must be 1 or 2");
  end
  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("sm4_tbox_pipe: LANES must be 1..4");
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar j = 0; j < 4; j++) begin : g_byte
      sm4_sbox_lut u_sbox (.a_i(in_data_i[32*k+8*j +: 8]), .s_o(tau_w[32*k+8*j +: 8]));
    end
    assign lin_w[32*k +: 32] = sm4_lin(fm, fd[32*k +: 32]);
  end
  // The "front" (fv/fd/fm/ft) is stage 1 when STAGES=2, or the raw input when STAGES=1.
  if (STAGES == 2) begin : g_s2
    logic v1_q, v1_d, acc;
    logic [W-1:0] d1_q, d1_d;
    sm4_tmode_e m1_q, m1_d;
    logic [TAG_W-1:0] t1_q, t1_d;
    // stage 1 captures tau(data), mode and tag on accept, holds otherwise
    always_comb begin
      acc = in_valid_i & in_ready_o;
      v1_d = acc | (v1_q & !ld2);
      d1_d = acc ? tau_w : d1_q;
      m1_d = acc ? sm4_tmode_e'(in_mode_i) : m1_q;
      t1_d = acc ? in_tag_i : t1_q;
    end
    // stage 1 registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v1_q <= 1'b0;
        d1_q <= '0;
        m1_q <= T;
        t1_q <= '0;
      end else begin
        v1_q <= v1_d;
        d1_q <= d1_d;
        m1_q <= m1_d;
        t1_q <= t1_d;
      end
    end
    assign fv = v1_q;
    assign fd = d1_q;
    assign fm = m1_q;
    assign ft = t1_q;
    assign in_ready_o = !v1_q | ld2;
  end else begin : g_s1
    assign fv = in_valid_i;
    assign fd = tau_w;
    assign fm = sm4_tmode_e'(in_mode_i);
    assign ft = in_tag_i;
    assign in_ready_o = !v2_q | out_ready_i;
  end
  assign ld2 = fv & (!v2_q | out_ready_i);
  // output stage loads the linear result when empty or draining, holds under stall
  always_comb begin
    v2_d = ld2 | (v2_q & !out_ready_i);
    d2_d = ld2 ? lin_w : d2_q;
    t2_d = ld2 ? ft : t2_q;
  end
  // output stage registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2_q <= 1'b0;
      d2_q <= '0;
      t2_q <= '0;
    end else begin
      v2_q <= v2_d;
      d2_q <= d2_d;
      t2_q <= t2_d;
    end
  end
  assign out_valid_o = v2_q;
  assign out_data_o = d2_q;
  assign out_tag_o = t2_q;
endmodule

// File: tb/tb_sm4_tbox_pipe.sv
// tb_sm4_tbox_pipe: directed and scoreboard checks of sm4_tbox_pipe in 4-lane/2-stage and 1-lane/1-stage builds
module tb_sm4_tbox_pipe;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_mode;
  logic [3:0] in_tag, out_tag;
  logic [127:0] in_data, out_data;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [1:0] s_in_mode;
  logic [3:0] s_in_tag, s_out_tag;
  logic [31:0] s_in_data, s_out_data;
  int n_checks = 0, n_fail = 0;

  sm4_tbox_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mode_i(in_mode),
    .in_tag_i(in_tag), .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_tag_o(out_tag), .out_data_o(out_data));

  sm4_tbox_pipe #(.LANES(1), .STAGES(1), .TAG_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_mode_i(s_in_mode),
    .in_tag_i(s_in_tag), .in_data_i(s_in_data), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_tag_o(s_out_tag), .out_data_o(s_out_data));

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] rot(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} << n;
    return y[63:32];
  endfunction

  function automatic logic [31:0] ref_w(input logic [1:0] m, input logic [31:0] x);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = SB[x[8*i +: 8]];
    if (m == 2'b00) return b ^ rot(b, 2) ^ rot(b, 10) ^ rot(b, 18) ^ rot(b, 24);
    if (m == 2'b01) return b ^ rot(b, 13) ^ rot(b, 23);
    return b;
  endfunction

  function automatic logic [127:0] ref_b(input logic [1:0] m, input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_w(m, x[32*i +: 32]);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_mode = 2'b00; in_data = '1; in_tag = 4'hf; out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_mode = 2'b00; s_in_data = '1; s_in_tag = 4'hf; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s1_out_valid got %b want 0", s_out_valid); end
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s1_in_ready got %b want 1", s_in_ready); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept got %b want 0", out_valid); end
    end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_mode = 2'b00; in_data = 128'h0; in_tag = 4'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== {4{32'h5b5b5b5b}}) begin n_fail++; $display("FAIL lat_data got %h want %h", out_data, {4{32'h5b5b5b5b}}); end
    n_checks++; if (out_tag !== 4'd1) begin n_fail++; $display("FAIL lat_tag got %h want 1", out_tag); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_dup got %b want 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [1:0] md [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [127:0] dv [5] = '{128'h0, 128'h0, {4{32'h00010203}}, {4{32'h000000ff}},
                             {32'h00000000, 32'hffffffff, 32'h000000ff, 32'h00010203}};
    logic [127:0] ev [5] = '{{4{32'h5b5b5b5b}}, {4{32'h67676767}}, {4{32'hd690e9fe}}, {4{32'hd6d6d648}},
                             {32'hd6d6d6d6, 32'h48484848, 32'hd6d6d648, 32'hd690e9fe}};
    int n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = c < 5;
      if (c < 5) begin in_mode = md[c]; in_data = dv[c]; in_tag = 4'(c + 1); end
      @(negedge clk);
      if (out_valid) begin
        if (n < 5) begin
          n_checks++; if (out_data !== ev[n]) begin n_fail++; $display("FAIL mode_data[%0d] got %h want %h", n, out_data, ev[n]); end
          n_checks++; if (out_tag !== 4'(n + 1)) begin n_fail++; $display("FAIL mode_tag[%0d] got %0d want %0d", n, out_tag, n + 1); end
        end
        n++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL mode_count got %0d want 5", n); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] eq [$];
    logic [3:0] tq [$];
    logic [127:0] e;
    logic [3:0] t;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = c < 16;
      if (c < 16) begin
        in_mode = 2'($urandom_range(0, 3));
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_tag = 4'(c);
      end
      @(negedge clk);
      if (c < 16) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d got %b want 1", c, in_ready); end
      end
      if (c >= 2 && c < 18) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap c=%0d got %b want 1", c, out_valid); end
      end
      if (in_valid && in_ready) begin eq.push_back(ref_b(in_mode, in_data)); tq.push_back(in_tag); end
      if (out_valid) begin
        if (eq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_extra got tag %0d want none", out_tag);
        end else begin
          e = eq.pop_front(); t = tq.pop_front();
          n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data got %h want %h", out_data, e); end
          n_checks++; if (out_tag !== t) begin n_fail++; $display("FAIL b2b_tag got %0d want %0d", out_tag, t); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (got != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", got); end
  endtask

  task automatic test_backpressure();
    logic [1:0] md [3] = '{2'd0, 2'd1, 2'd2};
    logic [127:0] dv [3] = '{128'h0, 128'h0, {4{32'h00010203}}};
    logic [127:0] ev [3] = '{{4{32'h5b5b5b5b}}, {4{32'h67676767}}, {4{32'hd690e9fe}}};
    logic [127:0] hd = '0;
    logic [3:0] ht = '0;
    logic stall = 1'b0;
    int sent = 0, got = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = c >= 7;
      in_valid = sent < 3;
      if (sent < 3) begin in_mode = md[sent]; in_data = dv[sent]; in_tag = 4'(5 + sent); end
      @(negedge clk);
      if (c < 2) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_fill c=%0d got %b want 1", c, in_ready); end
      end
      if (c >= 2 && c < 7) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low c=%0d got %b want 0", c, in_ready); end
      end
      if (stall) begin
        n_checks++; if (out_data !== hd || out_tag !== ht) begin n_fail++; $display("FAIL bp_hold c=%0d got %h/%0d want %h/%0d", c, out_data, out_tag, hd, ht); end
      end
      stall = out_valid && !out_ready; hd = out_data; ht = out_tag;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (got < 3) begin
          n_checks++; if (out_data !== ev[got]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", got, out_data, ev[got]); end
          n_checks++; if (out_tag !== 4'(5 + got)) begin n_fail++; $display("FAIL bp_tag[%0d] got %0d want %0d", got, out_tag, 5 + got); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_data = {4{32'h00010203}}; in_tag = 4'd8;
    @(posedge clk); #1;
    in_tag = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rf_filled got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_async_clear got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rf_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_stale c=%0d got %b want 0", c, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_mode = 2'b00; in_data = 128'h0; in_tag = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_new_early got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rf_new_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== {4{32'h5b5b5b5b}}) begin n_fail++; $display("FAIL rf_new_data got %h want %h", out_data, {4{32'h5b5b5b5b}}); end
    n_checks++; if (out_tag !== 4'd3) begin n_fail++; $display("FAIL rf_new_tag got %0d want 3", out_tag); end
  endtask

  task automatic test_stages1();
    logic [31:0] eq [$];
    logic [3:0] tq [$];
    logic [31:0] e, hd = '0;
    logic [3:0] t, ht = '0;
    logic stall = 1'b0;
    int sent = 0, got = 0;
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_mode = 2'b00; s_in_data = 32'h0; s_in_tag = 4'd3;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid got %b want 1", s_out_valid); end
    n_checks++; if (s_out_data !== 32'h5b5b5b5b) begin n_fail++; $display("FAIL s1_data got %h want 5b5b5b5b", s_out_data); end
    n_checks++; if (s_out_tag !== 4'd3) begin n_fail++; $display("FAIL s1_tag got %0d want 3", s_out_tag); end
    @(posedge clk); #1;
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL s1_dup got %b want 0", s_out_valid); end
    for (int c = 0; c < 80; c++) begin
      s_in_valid = c < 60 && $urandom_range(0, 3) != 0;
      s_out_ready = c >= 60 || $urandom_range(0, 2) != 0;
      if (s_in_valid && !(stall && !s_in_ready)) begin
        s_in_mode = 2'($urandom_range(0, 3)); s_in_data = $urandom; s_in_tag = 4'(c);
      end
      @(negedge clk);
      n_checks++; if (s_in_ready !== (!s_out_valid || s_out_ready)) begin n_fail++; $display("FAIL s1_ready c=%0d got %b want %b", c, s_in_ready, !s_out_valid || s_out_ready); end
      if (stall) begin
        n_checks++; if (s_out_data !== hd || s_out_tag !== ht) begin n_fail++; $display("FAIL s1_hold c=%0d got %h/%0d want %h/%0d", c, s_out_data, s_out_tag, hd, ht); end
      end
      stall = s_out_valid && !s_out_ready; hd = s_out_data; ht = s_out_tag;
      if (s_in_valid && s_in_ready) begin eq.push_back(ref_w(s_in_mode, s_in_data)); tq.push_back(s_in_tag); sent++; end
      if (s_out_valid && s_out_ready) begin
        if (eq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL s1_extra got tag %0d want none", s_out_tag);
        end else begin
          e = eq.pop_front(); t = tq.pop_front();
          n_checks++; if (s_out_data !== e) begin n_fail++; $display("FAIL s1_sb_data got %h want %h", s_out_data, e); end
          n_checks++; if (s_out_tag !== t) begin n_fail++; $display("FAIL s1_sb_tag got %0d want %0d", s_out_tag, t); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    n_checks++; if (got != sent || sent == 0) begin n_fail++; $display("FAIL s1_count got %0d want %0d", got, sent); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    test_stages1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sm4_tbox_pipe.md
# sm4_tbox_pipe

Parametrised, pipelined SM4 T-transform unit for the SM4 datapath. Each beat carries `LANES` independent 32-bit words. Each word goes through the nonlinear τ substitution (four byte S-boxes), then through one of two linear transforms: L for the round function, or L′ for key expansion. The block sits between round-input XOR logic and the round-state registers, and uses a valid/ready handshake so that encryption and key-schedule traffic can share one instance.

## Interface

Parameters:
- `LANES`, 1: number of independent 32-bit words per beat (1..4).
- `STAGES`, 2: pipeline register stages (1 or 2); any other value is a compile-time error.
- `TAG_W`, 4: width of the sideband tag carried alongside the data.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Asynchronous, active-high.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  block accepts the input beat this cycle.
- `in_mode_i`  in  2  transform select: 00 = T (L), 01 = T′ (L′), 10 = τ only, 11 = τ only.
- `in_tag_i`  in  TAG_W  sideband, passed through unchanged.
- `in_data_i`  in  32*LANES  lane k occupies bits [32k+31:32k].
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `out_tag_o`  out  TAG_W  tag of the result beat.
- `out_data_o`  out  32*LANES  transformed words, same lane order as the input.

## Operation

- τ: each byte b of a word is replaced by S(b), using the standard GB/T 32907 SM4 S-box (for example S(00)=d6, S(01)=90, S(02)=e9, S(03)=fe, S(ff)=48).
- L(B) = B ^ rotl(B,2) ^ rotl(B,10) ^ rotl(B,18) ^ rotl(B,24).
- L′(B) = B ^ rotl(B,13) ^ rotl(B,23).
- All rotations are within 32 bits. Lanes are fully independent of each other.
- The mode and tag are captured together with the data and travel with the beat through every stage.
- With STAGES=2:
  - Stage 1 registers τ(data), mode and tag.
  - Stage 2 registers the linear-transform result and tag.
- With STAGES=1: τ and the linear transform are computed combinationally in one step and registered once.
- Each stage holds a valid bit. A stage loads when it is empty, or when its contents advance downstream in the same cycle.
- `in_ready_o` = !v1 | (stage 1 advances this cycle). Stage 1 advances when stage 2 can load (STAGES=2), or when `out_ready_i` is high (STAGES=1).
- The ready chain is combinational back from `out_ready_i`. There is no skid buffer; full throughput is one beat per cycle.
- Input is accepted on in_valid_i & in_ready_o. Output is consumed on out_valid_o & out_ready_i.
- Stall behaviour: while out_valid_o=1 and out_ready_i=0, `out_data_o` and `out_tag_o` hold stable, and no beat is dropped or duplicated.
- Simultaneous accept and consume on a full pipe: both occur in the same cycle and the occupancy is unchanged.
- Reset mid-operation: all valid bits clear immediately. Any beats in flight are discarded, and there is no output for them after reset.

## Timing

- Latency is `STAGES` cycles from input acceptance to out_valid_o, given no backpressure.
- The pipeline holds at most `STAGES` beats in flight.
- Reset values:
  - out_valid_o = 0.
  - out_data_o = 0 and out_tag_o = 0 (data registers are reset too).
  - in_ready_o = 1 once rst_i deasserts. While in reset, in_ready_o = 1 but no beat is accepted.
- in_ready_o depends combinationally on out_ready_i. out_valid_o, out_data_o and out_tag_o are direct register outputs.

## Structure

- Package `sm4_pkg` holds:
  - The 256-entry S-box constant.
  - The mode enum `sm4_tmode_e` (T, TP, TAU, TAU_ALT).
  - The functions `sm4_l` and `sm4_lp`.
- Sub-module `sm4_sbox_lut`: a combinational 8→8 lookup built from the package constant. Instantiate 4*LANES copies in the τ stage.
- Top-level contents: per-stage valid/data/tag registers, the lane generate loop, and the ready chain.

## Test plan

- LANES=1, STAGES=2, mode T, data 0x00000000, out_ready held 1 → out_data 0x5b5b5b5b exactly 2 cycles after acceptance.
- Mode T′, data 0x00000000 → 0x67676767. Mode τ-only, data 0x00010203 → 0xd690e9fe. Tags 1, 2, 3 come out in order.
- LANES=4, back-to-back stream of 16 beats with random mode, out_ready=1 → one result per cycle, each matching the reference model per lane, and in_ready_o stays 1 throughout.
- Backpressure:
  - Fill the pipe, then hold out_ready=0 for 5 cycles → in_ready_o falls once 2 beats are held, and out_data/out_tag stay stable.
  - Release out_ready → no loss or duplication.
- Assert rst_i for one cycle with 2 beats in flight → out_valid_o goes 0 asynchronously. After release, no stale output appears, and a new beat 0x00000000/T yields 0x5b5b5b5b.
- STAGES=1 build, mode T, data 0x00000000 → 0x5b5b5b5b after 1 cycle. Random stall/valid traffic matches the scoreboard.
